// File: rtl/window_3x3_gen_pkg.sv
// Shared types and defaults for the 3x3 sliding-window generator.
package window_3x3_gen_pkg;

  typedef logic [7:0]  pixel_t;
  typedef logic [15:0] coord_t;

  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    FILL     = 2'd1,
    STREAM   = 2'd2
  } state_e;

endpackage

// File: rtl/window_3x3_gen_line_buffer.sv
// One-line pixel delay: combinational read of the old value and a write at the same address.
module line_buffer
  import window_3x3_gen_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_WIDTH,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  pixel_t        wdata,
  output pixel_t        rdata
);

  // No reset: contents only reach a valid window after being rewritten in the current frame.
  pixel_t mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/window_3x3_gen.sv
// 3x3 raster window generator with two line buffers.
// Optional WIN_COORD_EN adds registered window-centre coordinates (win_x, win_y).
//
// state    | meaning
// WAIT_SOF | idle, dropping pixels until pix_valid && sof
// FILL     | rows 0-1 loading the line buffers, no windows possible
// STREAM   | row 2 onward, windows emitted for x>=2
module window_3x3_gen
  import window_3x3_gen_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic   clk,
  input  logic   rst_n,
  input  pixel_t pix_in,
  input  logic   pix_valid,
  input  logic   sof,
  output pixel_t px0,
  output pixel_t px1,
  output pixel_t px2,
  output pixel_t px3,
  output pixel_t px4,
  output pixel_t px5,
  output pixel_t px6,
  output pixel_t px7,
  output pixel_t px8,
  output logic   win_valid
`ifdef WIN_COORD_EN
  ,
  output coord_t win_x,
  output coord_t win_y
`endif
);

  localparam int     AW     = $clog2(IMG_WIDTH);
  localparam coord_t LAST_X = coord_t'(IMG_WIDTH - 1);
  localparam coord_t LAST_Y = coord_t'(IMG_HEIGHT - 1);

  state_e state, state_nxt;
  coord_t col, row;
  coord_t cur_x, cur_y;
  logic   start, take, at_last, emit;
  pixel_t lb0_rd, lb1_rd;
  pixel_t win [9];

  // sof restarts the frame from any state, so the accepted pixel's position is forced to (0,0).
  assign start   = pix_valid && sof;
  assign take    = pix_valid && (sof || state != WAIT_SOF);
  assign cur_x   = start ? '0 : col;
  assign cur_y   = start ? '0 : row;
  assign at_last = (cur_x == LAST_X) && (cur_y == LAST_Y);

  line_buffer #(.DEPTH(IMG_WIDTH)) u_lb0 (
    .clk  (clk),
    .we   (take),
    .addr (cur_x[AW-1:0]),
    .wdata(pix_in),
    .rdata(lb0_rd)
  );

  line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
    .clk  (clk),
    .we   (take),
    .addr (cur_x[AW-1:0]),
    .wdata(lb0_rd),
    .rdata(lb1_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_SOF;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      WAIT_SOF: if (start) state_nxt = FILL;
      FILL: begin
        if (start)                                      state_nxt = FILL;
        else if (take && cur_x == '0 && cur_y == 16'd2) state_nxt = STREAM;
      end
      STREAM: begin
        if (start)                state_nxt = FILL;
        else if (take && at_last) state_nxt = WAIT_SOF;
      end
      default: state_nxt = WAIT_SOF;
    endcase
  end

  always_comb begin
    emit = take && !start && (cur_x >= 16'd2) && (cur_y >= 16'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (take) begin
      if (at_last) begin
        col <= '0;
        row <= '0;
      end else if (cur_x == LAST_X) begin
        col <= '0;
        row <= cur_y + 16'd1;
      end else begin
        col <= cur_x + 16'd1;
        row <= cur_y;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) win[i] <= '0;
      win_valid <= 1'b0;
    end else begin
      win_valid <= emit;
      if (take) begin
        win[0] <= win[1];
        win[1] <= win[2];
        win[2] <= lb1_rd;
        win[3] <= win[4];
        win[4] <= win[5];
        win[5] <= lb0_rd;
        win[6] <= win[7];
        win[7] <= win[8];
        win[8] <= pix_in;
      end
    end
  end

`ifdef WIN_COORD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_x <= '0;
      win_y <= '0;
    end else if (emit) begin
      win_x <= cur_x - 16'd1;
      win_y <= cur_y - 16'd1;
    end
  end
`endif

  assign px0 = win[0];
  assign px1 = win[1];
  assign px2 = win[2];
  assign px3 = win[3];
  assign px4 = win[4];
  assign px5 = win[5];
  assign px6 = win[6];
  assign px7 = win[7];
  assign px8 = win[8];

endmodule

// File: tb/tb_window_3x3_gen.sv
// Scoreboard bench for window_3x3_gen on an 8x6 image; a frame-array model predicts each window.
module tb_window_3x3_gen;
  import window_3x3_gen_pkg::*;

  localparam int W = 8;
  localparam int H = 6;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  pixel_t pix_in;
  logic   pix_valid, sof;
  pixel_t px0, px1, px2, px3, px4, px5, px6, px7, px8;
  logic   win_valid;
`ifdef WIN_COORD_EN
  coord_t win_x, win_y;
`endif

  window_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
    .px0(px0), .px1(px1), .px2(px2), .px3(px3), .px4(px4),
    .px5(px5), .px6(px6), .px7(px7), .px8(px8),
    .win_valid(win_valid)
`ifdef WIN_COORD_EN
    , .win_x(win_x), .win_y(win_y)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [71:0] pix;
    int          cyc;
    logic [15:0] x;
    logic [15:0] y;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [71:0] seen_q[$];
  logic [15:0] seen_x[$];
  logic [15:0] seen_y[$];
  int          checks = 0;
  int          failures = 0;

  // Reference model: the current frame as a 2D array plus a raster position.
  pixel_t img [H][W];
  bit     in_frame = 0;
  int     mx, my;

  wire [71:0] dut_win = {px8, px7, px6, px5, px4, px3, px2, px1, px0};

  function automatic void check(input string name, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  always @(negedge clk) begin
    if (win_valid) begin
      seen_q.push_back(dut_win);
`ifdef WIN_COORD_EN
      seen_x.push_back(win_x);
      seen_y.push_back(win_y);
`endif
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_window actual=%0h required=no_window cyc=%0d", dut_win, cyc);
      end else begin
        e = exp_q.pop_front();
        check("window_pixels", dut_win, e.pix);
        check("window_cycle", 72'(cyc), 72'(e.cyc));
`ifdef WIN_COORD_EN
        check("window_x", 72'(win_x), 72'(e.x));
        check("window_y", 72'(win_y), 72'(e.y));
`endif
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_window actual=no_window required=%0h cyc=%0d", e.pix, e.cyc);
    end
  end

  task automatic send(input pixel_t p, input logic v, input logic s);
    exp_t n;
    @(posedge clk);
    #1;
    pix_in = p;
    pix_valid = v;
    sof = s;
    if (v) begin
      if (s) begin
        in_frame = 1;
        mx = 0;
        my = 0;
      end
      if (in_frame) begin
        img[my][mx] = p;
        if (mx >= 2 && my >= 2) begin
          n.pix = '0;
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              n.pix[(r*3+c)*8 +: 8] = img[my-2+r][mx-2+c];
          n.cyc = cyc + 1;
          n.x = 16'(mx - 1);
          n.y = 16'(my - 1);
          exp_q.push_back(n);
        end
        mx++;
        if (mx == W) begin
          mx = 0;
          my++;
          if (my == H) in_frame = 0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) send(8'h00, 1'b0, 1'b0);
  endtask

  task automatic ramp_frame(input bit alt);
    for (int i = 0; i < W*H; i++) begin
      send(pixel_t'(i), 1'b1, i == 0);
      if (alt) send(8'h00, 1'b0, 1'b0);
    end
  endtask

  task automatic rand_frame();
    for (int i = 0; i < W*H; i++) begin
      while ($urandom_range(3) == 0) send(pixel_t'($urandom), 1'b0, 1'($urandom_range(1)));
      send(pixel_t'($urandom), 1'b1, i == 0);
    end
  endtask

  task automatic clear_seen();
    seen_q.delete();
    seen_x.delete();
    seen_y.delete();
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    pix_valid = 1'b0;
    sof = 1'b0;
    exp_q.delete();
    in_frame = 0;
    #1;
    check("reset_win_valid", 72'(win_valid), 72'(0));
    check("reset_window", dut_win, 72'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  pixel_t p0;

  initial begin
    pix_in = '0;
    pix_valid = 1'b0;
    sof = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("por_win_valid", 72'(win_valid), 72'(0));
    check("por_window", dut_win, 72'(0));
`ifdef WIN_COORD_EN
    check("por_win_x", 72'(win_x), 72'(0));
    check("por_win_y", 72'(win_y), 72'(0));
`endif
    rst_n = 1'b1;

    // continuous ramp
    clear_seen();
    ramp_frame(0);
    idle(3);
    check("ramp_count", 72'(seen_q.size()), 72'(24));
    if (seen_q.size() == 24) begin
      check("ramp_first_px0", 72'(seen_q[0][7:0]), 72'(0));
      check("ramp_first_px4", 72'(seen_q[0][39:32]), 72'(9));
      check("ramp_first_px8", 72'(seen_q[0][71:64]), 72'(18));
      check("ramp_last_px8", 72'(seen_q[23][71:64]), 72'(47));
`ifdef WIN_COORD_EN
      check("ramp_first_x", 72'(seen_x[0]), 72'(1));
      check("ramp_first_y", 72'(seen_y[0]), 72'(1));
      check("ramp_last_x", 72'(seen_x[23]), 72'(6));
      check("ramp_last_y", 72'(seen_y[23]), 72'(4));
`endif
    end

    // ramp with pix_valid alternating
    clear_seen();
    ramp_frame(1);
    idle(3);
    check("alt_count", 72'(seen_q.size()), 72'(24));
    if (seen_q.size() == 24) check("alt_first_px4", 72'(seen_q[0][39:32]), 72'(9));

    // reset, pixels without sof, then a framed ramp
    reset_dut();
    clear_seen();
    for (int i = 0; i < 20; i++) send(pixel_t'($urandom), 1'b1, 1'b0);
    idle(2);
    check("no_sof_windows", 72'(seen_q.size()), 72'(0));
    ramp_frame(0);
    idle(3);
    check("post_reset_ramp_count", 72'(seen_q.size()), 72'(24));

    // sof reasserted at (5,3)
    clear_seen();
    for (int i = 0; i < 3*W+5; i++) send(pixel_t'(i), 1'b1, i == 0);
    p0 = pixel_t'($urandom);
    send(p0, 1'b1, 1'b1);
    for (int i = 1; i < W*H; i++) send(pixel_t'($urandom), 1'b1, 1'b0);
    idle(3);
    check("restart_count", 72'(seen_q.size()), 72'(9 + 24));
    if (seen_q.size() > 9) check("restart_px0", 72'(seen_q[9][7:0]), 72'(p0));

    // reset in the middle of STREAM
    for (int i = 0; i < 30; i++) send(pixel_t'(i), 1'b1, i == 0);
    reset_dut();
    clear_seen();
    for (int i = 0; i < 10; i++) send(pixel_t'($urandom), 1'b1, 1'b0);
    idle(2);
    check("after_reset_no_sof", 72'(seen_q.size()), 72'(0));
    rand_frame();
    idle(3);
    check("after_reset_frame_count", 72'(seen_q.size()), 72'(24));

    // back-to-back random frames with random gaps
    clear_seen();
    repeat (3) rand_frame();
    idle(5);
    check("random_frames_count", 72'(seen_q.size()), 72'(72));
    check("scoreboard_drained", 72'(exp_q.size()), 72'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
